// File: rtl/picorv32_axi_slave_mem.sv
// AXI4-lite responder bridging an AXI4-lite master onto the picorv32 native
// mem_valid/mem_ready handshake. One transaction in flight; AW, W and AR each
// have a one-entry holding buffer so masters can run ahead of the memory.
module picorv32_axi_slave_mem #(
   parameter int unsigned READ_FIRST  = 0,
   parameter int unsigned FORCE_ALIGN = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_axi_awvalid,
   output logic        mem_axi_awready,
   input  logic [31:0] mem_axi_awaddr,
   input  logic [2:0]  mem_axi_awprot,
   input  logic        mem_axi_wvalid,
   output logic        mem_axi_wready,
   input  logic [31:0] mem_axi_wdata,
   input  logic [3:0]  mem_axi_wstrb,
   output logic        mem_axi_bvalid,
   input  logic        mem_axi_bready,
   input  logic        mem_axi_arvalid,
   output logic        mem_axi_arready,
   input  logic [31:0] mem_axi_araddr,
   input  logic [2:0]  mem_axi_arprot,
   output logic        mem_axi_rvalid,
   input  logic        mem_axi_rready,
   output logic [31:0] mem_axi_rdata,
   output logic        mem_valid,
   output logic        mem_instr,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StMem, StBresp, StRresp} state_e;

   state_e      state_q, state_d;
   logic        aw_full_q, aw_full_d;
   logic [31:0] aw_addr_q, aw_addr_d;
   logic        w_full_q, w_full_d;
   logic [31:0] w_data_q, w_data_d;
   logic [3:0]  w_strb_q, w_strb_d;
   logic        ar_full_q, ar_full_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   logic        ar_instr_q, ar_instr_d;
   logic        last_read_q, last_read_d;
   logic        cur_read_q, cur_read_d;
   logic        mem_valid_q, mem_valid_d;
   logic        mem_instr_q, mem_instr_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic        bvalid_q, bvalid_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;

   logic write_elig, issue, pick_read, mem_done;
   logic unused_prot;

   // Protection bits other than the instruction-fetch flag carry no meaning here
   assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot[1:0]};

   assign write_elig = aw_full_q && w_full_q;
   assign issue      = (state_q == StIdle) && (write_elig || ar_full_q);
   // Tie: fixed read priority, or alternate against the last served type
   assign pick_read  = ar_full_q && (!write_elig || (READ_FIRST != 0) || !last_read_q);
   assign mem_done   = (state_q == StMem) && mem_ready;

   assign mem_axi_awready = !aw_full_q;
   assign mem_axi_wready  = !w_full_q;
   assign mem_axi_arready = !ar_full_q;
   assign mem_axi_bvalid  = bvalid_q;
   assign mem_axi_rvalid  = rvalid_q;
   assign mem_axi_rdata   = rdata_q;
   assign mem_valid       = mem_valid_q;
   assign mem_instr       = mem_instr_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;
   assign mem_wstrb       = mem_wstrb_q;

   function automatic logic [31:0] align_addr(input logic [31:0] a);
      return (FORCE_ALIGN != 0) ? {a[31:2], 2'b00} : a;
   endfunction

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         aw_full_q   <= 1'b0;
         aw_addr_q   <= '0;
         w_full_q    <= 1'b0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         ar_full_q   <= 1'b0;
         ar_addr_q   <= '0;
         ar_instr_q  <= 1'b0;
         last_read_q <= 1'b0;
         cur_read_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_instr_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         bvalid_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         aw_full_q   <= aw_full_d;
         aw_addr_q   <= aw_addr_d;
         w_full_q    <= w_full_d;
         w_data_q    <= w_data_d;
         w_strb_q    <= w_strb_d;
         ar_full_q   <= ar_full_d;
         ar_addr_q   <= ar_addr_d;
         ar_instr_q  <= ar_instr_d;
         last_read_q <= last_read_d;
         cur_read_q  <= cur_read_d;
         mem_valid_q <= mem_valid_d;
         mem_instr_q <= mem_instr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         bvalid_q    <= bvalid_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
      end
   end

   // Next-state: one request to memory, then its response, then back to idle
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (issue) state_d = StMem;
         StMem:   if (mem_ready) state_d = cur_read_q ? StRresp : StBresp;
         StBresp: if (mem_axi_bready) state_d = StIdle;
         StRresp: if (mem_axi_rready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Holding buffers: capture when empty, release when memory completes the request
   always_comb begin
      aw_full_d  = aw_full_q;
      aw_addr_d  = aw_addr_q;
      w_full_d   = w_full_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      ar_full_d  = ar_full_q;
      ar_addr_d  = ar_addr_q;
      ar_instr_d = ar_instr_q;
      if (mem_done && !cur_read_q) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
      end
      if (mem_done && cur_read_q) ar_full_d = 1'b0;
      if (mem_axi_awvalid && !aw_full_q) begin
         aw_full_d = 1'b1;
         aw_addr_d = mem_axi_awaddr;
      end
      if (mem_axi_wvalid && !w_full_q) begin
         w_full_d = 1'b1;
         w_data_d = mem_axi_wdata;
         w_strb_d = mem_axi_wstrb;
      end
      if (mem_axi_arvalid && !ar_full_q) begin
         ar_full_d  = 1'b1;
         ar_addr_d  = mem_axi_araddr;
         ar_instr_d = mem_axi_arprot[2];
      end
   end

   // Registered outputs: native request launch/retire and AXI responses
   always_comb begin
      last_read_d = last_read_q;
      cur_read_d  = cur_read_q;
      mem_valid_d = mem_valid_q;
      mem_instr_d = mem_instr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      bvalid_d    = bvalid_q;
      rvalid_d    = rvalid_q;
      rdata_d     = rdata_q;
      if (issue) begin
         mem_valid_d = 1'b1;
         cur_read_d  = pick_read;
         last_read_d = pick_read;
         if (pick_read) begin
            mem_addr_d  = align_addr(ar_addr_q);
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            mem_instr_d = ar_instr_q;
         end else begin
            mem_addr_d  = align_addr(aw_addr_q);
            mem_wdata_d = w_data_q;
            mem_wstrb_d = w_strb_q;
            mem_instr_d = 1'b0;
         end
      end
      if (mem_done) begin
         mem_valid_d = 1'b0;
         if (cur_read_q) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_rdata;
         end else begin
            bvalid_d = 1'b1;
         end
      end
      if ((state_q == StBresp) && mem_axi_bready) bvalid_d = 1'b0;
      if ((state_q == StRresp) && mem_axi_rready) rvalid_d = 1'b0;
   end

endmodule

// File: tb/tb_picorv32_axi_slave_mem.sv
// Bench for picorv32_axi_slave_mem: directed scenarios with literal expectations,
// then random AXI/native traffic checked every cycle against a queue-based model.
module tb_picorv32_axi_slave_mem;

   localparam int unsigned ReadFirst  = 0;
   localparam int unsigned ForceAlign = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_axi_awvalid, mem_axi_awready;
   logic [31:0] mem_axi_awaddr;
   logic [2:0]  mem_axi_awprot;
   logic        mem_axi_wvalid, mem_axi_wready;
   logic [31:0] mem_axi_wdata;
   logic [3:0]  mem_axi_wstrb;
   logic        mem_axi_bvalid, mem_axi_bready;
   logic        mem_axi_arvalid, mem_axi_arready;
   logic [31:0] mem_axi_araddr;
   logic [2:0]  mem_axi_arprot;
   logic        mem_axi_rvalid, mem_axi_rready;
   logic [31:0] mem_axi_rdata;
   logic        mem_valid, mem_instr, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   always #5 clk = ~clk;

   picorv32_axi_slave_mem #(
      .READ_FIRST (ReadFirst),
      .FORCE_ALIGN(ForceAlign)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_axi_awvalid(mem_axi_awvalid),
      .mem_axi_awready(mem_axi_awready),
      .mem_axi_awaddr (mem_axi_awaddr),
      .mem_axi_awprot (mem_axi_awprot),
      .mem_axi_wvalid (mem_axi_wvalid),
      .mem_axi_wready (mem_axi_wready),
      .mem_axi_wdata  (mem_axi_wdata),
      .mem_axi_wstrb  (mem_axi_wstrb),
      .mem_axi_bvalid (mem_axi_bvalid),
      .mem_axi_bready (mem_axi_bready),
      .mem_axi_arvalid(mem_axi_arvalid),
      .mem_axi_arready(mem_axi_arready),
      .mem_axi_araddr (mem_axi_araddr),
      .mem_axi_arprot (mem_axi_arprot),
      .mem_axi_rvalid (mem_axi_rvalid),
      .mem_axi_rready (mem_axi_rready),
      .mem_axi_rdata  (mem_axi_rdata),
      .mem_valid      (mem_valid),
      .mem_instr      (mem_instr),
      .mem_ready      (mem_ready),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wstrb      (mem_wstrb),
      .mem_rdata      (mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        rd;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } txn_t;

   logic [31:0] q_aw[$];
   logic [35:0] q_w[$];
   logic [32:0] q_ar[$];
   txn_t        m_cur;
   logic        m_req = 1'b0, m_b = 1'b0, m_r = 1'b0, m_last_rd = 1'b0, m_live = 1'b0;
   logic [31:0] m_rdata = '0;

   function automatic logic [31:0] al(input logic [31:0] a);
      return (ForceAlign != 0) ? {a[31:2], 2'b00} : a;
   endfunction

   initial forever begin : model
      bit awr, wr, arr, can_w, can_r, take_r;
      @(posedge clk);
      if (reset) begin
         q_aw.delete(); q_w.delete(); q_ar.delete();
         m_req = 0; m_b = 0; m_r = 0; m_last_rd = 0; m_live = 1; m_cur = '0; m_rdata = '0;
      end else if (m_live) begin
         // each buffer holds at most one item; readiness seen before this edge
         awr = (q_aw.size() == 0);
         wr  = (q_w.size() == 0);
         arr = (q_ar.size() == 0);
         if (m_req) begin
            if (mem_ready) begin
               m_req = 0;
               if (m_cur.rd) begin
                  m_r = 1; m_rdata = mem_rdata; q_ar.delete(0);
               end else begin
                  m_b = 1; q_aw.delete(0); q_w.delete(0);
               end
            end
         end else if (m_b) begin
            if (mem_axi_bready) m_b = 0;
         end else if (m_r) begin
            if (mem_axi_rready) m_r = 0;
         end else begin
            can_w = (q_aw.size() > 0) && (q_w.size() > 0);
            can_r = (q_ar.size() > 0);
            if (can_w || can_r) begin
               if (can_w && can_r) take_r = (ReadFirst != 0) ? 1'b1 : !m_last_rd;
               else take_r = can_r;
               m_last_rd = take_r;
               m_req = 1;
               m_cur.rd = take_r;
               if (take_r) begin
                  m_cur.addr = al(q_ar[0][31:0]); m_cur.instr = q_ar[0][32];
                  m_cur.wdata = '0; m_cur.strb = '0;
               end else begin
                  m_cur.addr = al(q_aw[0]); m_cur.instr = 1'b0;
                  m_cur.wdata = q_w[0][31:0]; m_cur.strb = q_w[0][35:32];
               end
            end
         end
         if (mem_axi_awvalid && awr) q_aw.push_back(mem_axi_awaddr);
         if (mem_axi_wvalid && wr)   q_w.push_back({mem_axi_wstrb, mem_axi_wdata});
         if (mem_axi_arvalid && arr) q_ar.push_back({mem_axi_arprot[2], mem_axi_araddr});
      end
   end

   // Per-cycle comparison, mid-cycle while everything is settled
   initial forever begin
      @(negedge clk);
      if (m_live) begin
         chk("awready", mem_axi_awready, q_aw.size() == 0);
         chk("wready", mem_axi_wready, q_w.size() == 0);
         chk("arready", mem_axi_arready, q_ar.size() == 0);
         chk("mem_valid", mem_valid, m_req);
         chk("bvalid", mem_axi_bvalid, m_b);
         chk("rvalid", mem_axi_rvalid, m_r);
         if (m_req) begin
            chk("mem_addr", mem_addr, m_cur.addr);
            chk("mem_wdata", mem_wdata, m_cur.wdata);
            chk("mem_wstrb", mem_wstrb, m_cur.strb);
            chk("mem_instr", mem_instr, m_cur.instr);
         end
         if (m_r) chk("rdata", mem_axi_rdata, m_rdata);
      end
   end

   // ---------------- stimulus ----------------
   logic aw_hs, w_hs, ar_hs;

   // Advance one clock; handshake flags reflect the edge just taken
   task automatic step();
      @(negedge clk);
      aw_hs = mem_axi_awvalid && mem_axi_awready;
      w_hs  = mem_axi_wvalid && mem_axi_wready;
      ar_hs = mem_axi_arvalid && mem_axi_arready;
      @(posedge clk);
      #1;
   endtask

   logic order[$];
   logic prev_mv;

   initial begin
      reset = 1'b1;
      mem_axi_awvalid = 0; mem_axi_awaddr = '0; mem_axi_awprot = '0;
      mem_axi_wvalid = 0; mem_axi_wdata = '0; mem_axi_wstrb = '0;
      mem_axi_arvalid = 0; mem_axi_araddr = '0; mem_axi_arprot = '0;
      mem_axi_bready = 0; mem_axi_rready = 0;
      mem_ready = 0; mem_rdata = '0;
      step(); step();
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_awready", mem_axi_awready, 1);
      chk("rst_arready", mem_axi_arready, 1);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata", mem_axi_rdata, 0);
      reset = 1'b0;

      // Single write, AW and W together, zero-wait memory
      mem_axi_awvalid = 1; mem_axi_awaddr = 32'h0000_0104;
      mem_axi_wvalid = 1; mem_axi_wdata = 32'hDEAD_BEEF; mem_axi_wstrb = 4'b0011;
      mem_ready = 1;
      step();
      mem_axi_awvalid = 0; mem_axi_wvalid = 0;
      chk("t1_hs", aw_hs && w_hs, 1);
      chk("t1_mv_e0", mem_valid, 0);
      step();
      chk("t1_mv_e1", mem_valid, 1);
      chk("t1_addr", mem_addr, 32'h104);
      chk("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t1_wstrb", mem_wstrb, 4'b0011);
      step();
      chk("t1_bvalid_e2", mem_axi_bvalid, 1);
      chk("t1_mv_e2", mem_valid, 0);
      mem_axi_bready = 1;
      step();
      chk("t1_bvalid_e3", mem_axi_bvalid, 0);

      // W five cycles ahead of AW
      mem_axi_wvalid = 1; mem_axi_wdata = 32'hCAFE_0001; mem_axi_wstrb = 4'b1100;
      step();
      mem_axi_wvalid = 0;
      chk("t2_wready", mem_axi_wready, 0);
      chk("t2_awready", mem_axi_awready, 1);
      repeat (4) begin
         step();
         chk("t2_no_mv", mem_valid, 0);
      end
      mem_axi_awvalid = 1; mem_axi_awaddr = 32'h0000_0202;
      step();
      mem_axi_awvalid = 0;
      chk("t2_mv_e0", mem_valid, 0);
      step();
      chk("t2_mv", mem_valid, 1);
      chk("t2_addr", mem_addr, 32'h200);
      chk("t2_wdata", mem_wdata, 32'hCAFE_0001);
      chk("t2_wstrb", mem_wstrb, 4'b1100);
      step();
      chk("t2_bvalid", mem_axi_bvalid, 1);
      step();
      chk("t2_bdone", mem_axi_bvalid, 0);

      // Instruction-fetch read, unaligned address, slow memory, slow master
      mem_ready = 0; mem_axi_rready = 0;
      mem_axi_arvalid = 1; mem_axi_araddr = 32'h0000_0013; mem_axi_arprot = 3'b100;
      step();
      mem_axi_arvalid = 0;
      step();
      chk("t3_mv", mem_valid, 1);
      chk("t3_addr", mem_addr, 32'h10);
      chk("t3_instr", mem_instr, 1);
      chk("t3_wstrb", mem_wstrb, 0);
      repeat (3) begin
         step();
         chk("t3_mv_wait", mem_valid, 1);
      end
      mem_ready = 1; mem_rdata = 32'h1234_5678;
      step();
      mem_ready = 0; mem_rdata = 32'h0BAD_0BAD;
      chk("t3_rvalid", mem_axi_rvalid, 1);
      chk("t3_mv_done", mem_valid, 0);
      repeat (3) begin
         step();
         chk("t3_rhold", mem_axi_rvalid, 1);
         chk("t3_rdata", mem_axi_rdata, 32'h1234_5678);
      end
      mem_axi_rready = 1;
      step();
      chk("t3_rdone", mem_axi_rvalid, 0);

      // Continuous read/write contention after reset: alternation starts with read
      reset = 1; step(); reset = 0;
      mem_axi_awvalid = 1; mem_axi_awaddr = 32'h0000_0800;
      mem_axi_wvalid = 1; mem_axi_wdata = 32'h5555_AAAA; mem_axi_wstrb = 4'hF;
      mem_axi_arvalid = 1; mem_axi_araddr = 32'h0000_0900; mem_axi_arprot = 3'b000;
      mem_ready = 1; mem_axi_bready = 1; mem_axi_rready = 1;
      prev_mv = 0;
      repeat (20) begin
         step();
         if (mem_valid && !prev_mv) order.push_back(mem_wstrb == 4'h0);
         prev_mv = mem_valid;
      end
      mem_axi_awvalid = 0; mem_axi_wvalid = 0; mem_axi_arvalid = 0;
      repeat (12) step();
      chk("t4_count", order.size() >= 4, 1);
      if (order.size() >= 4) begin
         chk("t4_order0", order[0], 1);
         chk("t4_order1", order[1], 0);
         chk("t4_order2", order[2], 1);
         chk("t4_order3", order[3], 0);
      end

      // Reset while a request is outstanding
      mem_ready = 0; mem_axi_rready = 0;
      mem_axi_arvalid = 1; mem_axi_araddr = 32'h0000_0040;
      step();
      mem_axi_arvalid = 0;
      step();
      chk("t5_mv", mem_valid, 1);
      reset = 1;
      step();
      reset = 0;
      chk("t5_mv_rst", mem_valid, 0);
      chk("t5_bvalid", mem_axi_bvalid, 0);
      chk("t5_rvalid", mem_axi_rvalid, 0);
      chk("t5_readies", {mem_axi_awready, mem_axi_wready, mem_axi_arready}, 3'b111);
      mem_ready = 1;
      repeat (3) begin
         step();
         chk("t5_no_r", mem_axi_rvalid, 0);
         chk("t5_no_mv", mem_valid, 0);
      end

      // B backpressure with a read waiting behind it
      mem_axi_bready = 0; mem_axi_rready = 1; mem_ready = 1;
      mem_axi_awvalid = 1; mem_axi_awaddr = 32'h0000_0300;
      mem_axi_wvalid = 1; mem_axi_wdata = 32'h1122_3344; mem_axi_wstrb = 4'hF;
      step();
      mem_axi_awvalid = 0; mem_axi_wvalid = 0;
      step(); step();
      chk("t6_bvalid", mem_axi_bvalid, 1);
      mem_axi_arvalid = 1; mem_axi_araddr = 32'h0000_0500; mem_axi_arprot = 3'b000;
      step();
      mem_axi_arvalid = 0;
      chk("t6_ar_hs", ar_hs, 1);
      repeat (9) begin
         step();
         chk("t6_no_mv", mem_valid, 0);
         chk("t6_bhold", mem_axi_bvalid, 1);
      end
      mem_axi_bready = 1;
      step();
      chk("t6_bdone", mem_axi_bvalid, 0);
      chk("t6_mv_idle", mem_valid, 0);
      step();
      chk("t6_rd_mv", mem_valid, 1);
      chk("t6_rd_addr", mem_addr, 32'h500);
      chk("t6_rd_wstrb", mem_wstrb, 0);
      repeat (3) step();

      // Random traffic
      repeat (4000) begin
         if (aw_hs) mem_axi_awvalid = 0;
         if (w_hs)  mem_axi_wvalid = 0;
         if (ar_hs) mem_axi_arvalid = 0;
         if (!mem_axi_awvalid && $urandom_range(0, 3) == 0) begin
            mem_axi_awvalid = 1; mem_axi_awaddr = $urandom; mem_axi_awprot = 3'($urandom);
         end
         if (!mem_axi_wvalid && $urandom_range(0, 3) == 0) begin
            mem_axi_wvalid = 1; mem_axi_wdata = $urandom; mem_axi_wstrb = 4'($urandom);
         end
         if (!mem_axi_arvalid && $urandom_range(0, 3) == 0) begin
            mem_axi_arvalid = 1; mem_axi_araddr = $urandom; mem_axi_arprot = 3'($urandom);
         end
         mem_axi_bready = 1'($urandom);
         mem_axi_rready = 1'($urandom);
         mem_ready = ($urandom_range(0, 2) != 0);
         mem_rdata = $urandom;
         reset = ($urandom_range(0, 399) == 0);
         if (reset) begin
            mem_axi_awvalid = 0; mem_axi_wvalid = 0; mem_axi_arvalid = 0;
         end
         step();
      end
      reset = 0;
      mem_axi_awvalid = 0; mem_axi_wvalid = 0; mem_axi_arvalid = 0;
      mem_ready = 1; mem_axi_bready = 1; mem_axi_rready = 1;
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/picorv32_axi_slave_mem.md
Name: picorv32_axi_slave_mem

Overview:
- AXI4-lite responder that terminates an AXI4-lite master port and converts it to the picorv32 native memory handshake (mem_valid/mem_ready).
- Lets native-interface memories and peripherals (SRAM, UART, timer models) sit behind any AXI4-lite master in the SoC and testbenches, including the AXI-wrapped core.
- Serves one transaction at a time. AW, W and AR each have independent one-entry holding buffers.

Parameters:
- READ_FIRST, 0: when a read and a write are both eligible in IDLE: 1 = read always wins; 0 = alternate, opposite of the last served type (first tie after reset goes to read).
- FORCE_ALIGN, 1: 1 = mem_addr[1:0] forced to 2'b00; 0 = address passed unmodified.

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- mem_axi_awvalid  input  1  write address valid
- mem_axi_awready  output  1  write address ready
- mem_axi_awaddr  input  32  write address
- mem_axi_awprot  input  3  write protection; accepted, ignored
- mem_axi_wvalid  input  1  write data valid
- mem_axi_wready  output  1  write data ready
- mem_axi_wdata  input  32  write data
- mem_axi_wstrb  input  4  write byte strobes
- mem_axi_bvalid  output  1  write response valid
- mem_axi_bready  input  1  write response ready
- mem_axi_arvalid  input  1  read address valid
- mem_axi_arready  output  1  read address ready
- mem_axi_araddr  input  32  read address
- mem_axi_arprot  input  3  read protection; bit 2 = instruction fetch
- mem_axi_rvalid  output  1  read data valid
- mem_axi_rready  input  1  read data ready
- mem_axi_rdata  output  32  read data
- mem_valid  output  1  native request valid
- mem_instr  output  1  native request is an instruction fetch
- mem_ready  input  1  native request complete
- mem_addr  output  32  native address
- mem_wdata  output  32  native write data
- mem_wstrb  output  4  native byte strobes; 0 = read
- mem_rdata  input  32  native read data; valid when mem_ready is high

Behaviour:
- Reset:
  - aw_full, w_full, ar_full = 0; state = IDLE.
  - mem_valid, bvalid, rvalid = 0; awready, wready, arready = 1 in the first cycle after reset.
  - mem_addr, mem_wdata, mem_wstrb, mem_instr, rdata = 0.
  - Reset mid-transaction discards all buffered and in-flight work. No B or R response is issued for it.
- Buffers:
  - awready = !aw_full, wready = !w_full, arready = !ar_full. All are registered and have no combinational path from any valid input.
  - A buffer captures on valid&&ready at the clock edge and sets its full flag.
  - AW and W may arrive in either order or in the same cycle.
- Eligibility: write eligible = aw_full && w_full; read eligible = ar_full.
- FSM states: IDLE, MEM, BRESP, RRESP.
- IDLE:
  - If an eligible request exists, choose one by READ_FIRST or alternation, then go to MEM.
  - On that edge, load mem_addr (aligned if FORCE_ALIGN) and set mem_valid = 1.
  - Write: mem_wdata = buffered wdata, mem_wstrb = buffered wstrb, mem_instr = 0.
  - Read: mem_wstrb = 0, mem_wdata = 0, mem_instr = arprot[2].
  - Record the chosen type as last-served.
- MEM:
  - mem_valid stays high and mem_addr/wdata/wstrb/instr stay stable until mem_ready is sampled high.
  - On the mem_ready edge: mem_valid <= 0.
  - Write on mem_ready: clear aw_full and w_full, bvalid <= 1, go to BRESP.
  - Read on mem_ready: rdata <= mem_rdata, clear ar_full, rvalid <= 1, go to RRESP.
  - mem_ready sampled while mem_valid = 0 is ignored.
- BRESP / RRESP:
  - bvalid (or rvalid, with rdata) is held stable until bready (or rready) is sampled high.
  - On that edge, valid <= 0 and the FSM returns to IDLE.
  - A ready input that is already high before valid asserts completes the handshake on the first valid cycle.
- Overlap: buffers accept the next AW/W/AR while in MEM/BRESP/RRESP if the buffer is empty. A cleared buffer's ready rises the cycle after the mem_ready edge.
- Latency, zero-wait memory and ready masters:
  - AW+W handshake at edge E0 → mem_valid high after E1.
  - mem_ready high in that cycle → bvalid high after E2; bready high → bvalid low after E3.
  - Reads follow the same timing.
  - Back-to-back throughput is one transaction per 3 cycles minimum.
- Ordering: at most one transaction is in flight. A response is always completed before the next mem_valid.

Test Plan:
- Single write: AW=0x0000_0104, W=0xDEAD_BEEF, wstrb=4'b0011, same cycle, mem_ready tied high → one mem_valid pulse with addr 0x104, wdata 0xDEADBEEF, wstrb 0011; bvalid 2 cycles after the handshake edge.
- Write with W 5 cycles before AW → wready drops after W is captured and awready stays high; mem_valid asserts only after AW is captured; mem_wstrb and mem_wdata equal the captured values.
- Read with arprot=3'b100, addr 0x0000_0013, FORCE_ALIGN=1, mem_ready after 4 wait cycles, mem_rdata=0x1234_5678 → mem_addr 0x10, mem_instr=1, mem_wstrb=0; rdata=0x12345678 held with rvalid while rready is low for 3 cycles.
- Read and write eligible together repeatedly, READ_FIRST=0 → served order R, W, R, W. With READ_FIRST=1, all reads are served before any write.
- Reset asserted while in MEM with mem_valid high → next cycle mem_valid=0, bvalid=0, rvalid=0, all readies=1. A mem_ready arriving afterwards produces no response.
- Backpressure: bready low 10 cycles while a new AR arrives → arready accepts the AR; no mem_valid occurs until the B handshake completes; the read then proceeds normally.
